// File: rtl/out_bcd_display.sv
// out_bcd_display: bus output register with a bit-serial binary-to-BCD
// converter (double dabble, one bit per mclk) feeding a time-multiplexed
// 7-segment display driver. The scan keeps running regardless of mclk_en.
module out_bcd_display #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned SCAN_DIV = 1024,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic                  mclk,
    input  logic                  i_reset,
    input  logic                  mclk_en,
    input  logic                  i_load_enable,
    input  logic [WIDTH-1:0]      i_load_data,
    output logic [WIDTH-1:0]      o_data,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DIGITS-1:0]     o_digit_sel,
    output logic [6:0]            o_seg
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned SW = $clog2(SCAN_DIV + 1);
    localparam int unsigned IW = $clog2(DIGITS + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shift_q;
    logic [BW-1:0]      scratch_q;
    logic [CW-1:0]      count_q;

    logic               load;
    logic [BW-1:0]      adj;
    logic [BW-1:0]      scratch_nx;
    logic [WIDTH-1:0]   shift_nx;

    logic [SW-1:0]      scan_q;
    logic [IW-1:0]      idx_q;
    logic               wrap;
    logic [IW-1:0]      idx_nx;
    logic [3:0]         cur_digit;
    logic               upper_nz;
    logic               blank;
    logic [6:0]         seg_nx;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign load = mclk_en & i_load_enable;

    // One double-dabble step: add 3 to each digit >=5, then shift {scratch,shift} left.
    always_comb begin
        adj = scratch_q;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
        {scratch_nx, shift_nx} = {adj, shift_q} << 1;
    end

    // Load register and conversion FSM; a load always wins over the final shift.
    always_ff @(posedge mclk) begin
        if (i_reset) begin
            state     <= S_IDLE;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_data    <= '0;
            o_bcd     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            count_q   <= '0;
        end else begin
            o_done <= 1'b0;
            if (load) begin
                o_data    <= i_load_data;
                shift_q   <= i_load_data;
                scratch_q <= '0;
                count_q   <= '0;
                state     <= S_SHIFT;
                o_busy    <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        o_busy <= 1'b0;
                    end
                    S_SHIFT: begin
                        scratch_q <= scratch_nx;
                        shift_q   <= shift_nx;
                        count_q   <= count_q + 1'b1;
                        if (count_q == CNT_LAST) begin
                            o_bcd  <= scratch_nx;
                            o_done <= 1'b1;
                            state  <= S_IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Next scan position and the segment pattern for it, with leading-zero blanking.
    always_comb begin
        wrap = (scan_q == SCAN_LAST);
        if (wrap) begin
            idx_nx = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            idx_nx = idx_q;
        end
        cur_digit = 4'd0;
        upper_nz  = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (32'(idx_nx) == k) begin
                cur_digit = o_bcd[4*k +: 4];
            end
            if (k >= 32'(idx_nx) && o_bcd[4*k +: 4] != 4'd0) begin
                upper_nz = 1'b1;
            end
        end
        blank  = (BLANK_LZ != 0) && (idx_nx != '0) && !upper_nz;
        seg_nx = blank ? 7'h00 : seg7(cur_digit);
    end

    // Scan counter and registered digit select/segments; segments also refresh
    // the edge after o_bcd changes (o_done high) so a new result shows without waiting.
    always_ff @(posedge mclk) begin
        if (i_reset) begin
            scan_q      <= '0;
            idx_q       <= '0;
            o_digit_sel <= DIGITS'(1);
            o_seg       <= 7'h3F;
        end else begin
            scan_q <= wrap ? '0 : scan_q + 1'b1;
            idx_q  <= idx_nx;
            if (wrap) begin
                o_digit_sel <= DIGITS'(1) << idx_nx;
            end
            if (wrap || o_done) begin
                o_seg <= seg_nx;
            end
        end
    end

endmodule

// File: tb/tb_out_bcd_display.sv
// tb_out_bcd_display: directed scenarios plus random traffic, checked every
// cycle against an arithmetic reference model of the output port.
module tb_out_bcd_display;

    localparam int W  = 8;
    localparam int D  = 3;
    localparam int SD = 4;

    logic           mclk;
    logic           i_reset;
    logic           mclk_en;
    logic           i_load_enable;
    logic [W-1:0]   i_load_data;
    logic [W-1:0]   o_data;
    logic [4*D-1:0] o_bcd;
    logic           o_busy;
    logic           o_done;
    logic [D-1:0]   o_digit_sel;
    logic [6:0]     o_seg;

    out_bcd_display #(
        .WIDTH    (W),
        .DIGITS   (D),
        .SCAN_DIV (SD),
        .BLANK_LZ (1)
    ) dut (
        .mclk          (mclk),
        .i_reset       (i_reset),
        .mclk_en       (mclk_en),
        .i_load_enable (i_load_enable),
        .i_load_data   (i_load_data),
        .o_data        (o_data),
        .o_bcd         (o_bcd),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_digit_sel   (o_digit_sel),
        .o_seg         (o_seg)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int total = 0;
    int bad   = 0;

    int seg_tab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

    // reference model state
    int m_data, m_val, m_pend, m_rem, m_done, m_cnt, m_idx, m_stable;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        int r = 0;
        int p = 1;
        for (int k = 0; k < D; k++) begin
            r += ((v / p) % 10) << (4 * k);
            p *= 10;
        end
        return r;
    endfunction

    function automatic int exp_seg(input int v, input int k);
        int p = 1;
        for (int j = 0; j < k; j++) p *= 10;
        if (k > 0 && v < p) return 0;
        return seg_tab[(v / p) % 10];
    endfunction

    task automatic step(input bit rst, input bit en, input bit le, input int d);
        i_reset       = rst;
        mclk_en       = en;
        i_load_enable = le;
        i_load_data   = 8'(d);
        @(posedge mclk);
        if (rst) begin
            m_data = 0; m_val = 0; m_rem = 0; m_done = 0;
            m_cnt = 0; m_idx = 0; m_stable = 1;
        end else begin
            m_done = 0;
            if (m_stable < 100) m_stable++;
            if (en && le) begin
                m_data = d;
                m_pend = d;
                m_rem  = W;
            end else if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_val    = m_pend;
                    m_done   = 1;
                    m_stable = 0;
                end
            end
            m_cnt++;
            if (m_cnt == SD) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % D;
            end
        end
        #1;
        check("data", int'(o_data), m_data);
        check("bcd", int'(o_bcd), to_bcd(m_val));
        check("busy", int'(o_busy), int'(m_rem > 0));
        check("done", int'(o_done), m_done);
        check("sel", int'(o_digit_sel), 1 << m_idx);
        check("onehot", int'($onehot(o_digit_sel)), 1);
        if (m_stable >= 1) check("seg", int'(o_seg), exp_seg(m_val, m_idx));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0);
    endtask

    initial begin
        i_reset = 1'b1; mclk_en = 1'b0; i_load_enable = 1'b0; i_load_data = '0;
        m_pend = 0;
        // reset, then convert 255
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 1, 255);
        idle(14);
        // strobe without clock enable has no effect
        for (int i = 0; i < 20; i++) step(0, 0, 1, $urandom_range(255));
        // reload mid-conversion
        step(0, 1, 1, 12);
        idle(2);
        step(0, 1, 1, 200);
        idle(14);
        // load on the same edge as the final shift
        step(0, 1, 1, 50);
        idle(7);
        step(0, 1, 1, 123);
        idle(14);
        // blanking patterns
        step(0, 1, 1, 7);
        idle(24);
        step(0, 1, 1, 105);
        idle(24);
        step(0, 1, 1, 0);
        idle(24);
        // reset in the middle of a conversion
        step(0, 1, 1, 77);
        idle(3);
        step(1, 1, 0, 0);
        idle(5);
        step(0, 1, 1, 99);
        idle(14);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(63) == 0, 1'($urandom_range(1)),
                 $urandom_range(3) == 0, $urandom_range(255));
        end
        idle(16);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
